// File: rtl/ntt_stage_ctrl_if.sv
// Bus between the NTT stage controller and its coefficient memory, twiddle ROM and host.
// The master side is the controller; the slave side is whoever starts passes and owns memory.
interface ntt_stage_ctrl_if #(
  parameter int LOG_N = 8
) ();
  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [LOG_N-1:0] rd_addr_a;
  logic [LOG_N-1:0] rd_addr_b;
  logic [LOG_N-1:0] tw_idx;
  logic [3:0]       stage;
  logic             wr_en;
  logic [LOG_N-1:0] wr_addr_a;
  logic [LOG_N-1:0] wr_addr_b;

  modport master (
    input  start,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx, stage,
    output wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx, stage,
    input  wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_stage_ctrl.sv
// In-place radix-2 NTT stage sequencer: issues one butterfly pair per cycle per stage,
// drains the butterfly pipeline between stages and replays addresses as write-backs.
module ntt_stage_ctrl #(
  parameter int LOG_N  = 8,
  parameter int BF_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  ntt_stage_ctrl_if.master bus
);

  localparam int D  = 1 + BF_LAT;
  localparam int KW = LOG_N - 1;

  localparam logic [KW-1:0]    K_LAST   = '1;
  localparam logic [KW-1:0]    K_ONE    = KW'(32'd1);
  localparam logic [2:0]       DRN_LAST = 3'(BF_LAT);
  localparam logic [3:0]       STG_LAST = 4'(LOG_N - 1);
  localparam logic [LOG_N-1:0] ONE_L    = LOG_N'(32'd1);
  localparam logic [LOG_N-1:0] HALF_TOP = ONE_L << (LOG_N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [3:0] shamt_f(input logic [3:0] s);
    return STG_LAST - s;
  endfunction

  function automatic logic [LOG_N-1:0] half_f(input logic [3:0] s);
    return HALF_TOP >> s;
  endfunction

  function automatic logic [LOG_N-1:0] grp_f(input logic [KW-1:0] k, input logic [3:0] s);
    logic [LOG_N-1:0] kk;
    kk = {1'b0, k};
    return kk >> shamt_f(s);
  endfunction

  // Butterfly group occupies 2*half consecutive words; j is the offset inside the group.
  function automatic logic [LOG_N-1:0] addr_a_f(input logic [KW-1:0] k, input logic [3:0] s);
    logic [LOG_N-1:0] kk;
    kk = {1'b0, k};
    return (grp_f(k, s) << (shamt_f(s) + 4'd1)) | (kk & (half_f(s) - ONE_L));
  endfunction

  function automatic logic [LOG_N-1:0] tw_f(input logic [KW-1:0] k, input logic [3:0] s);
    return ((ONE_L << s) - ONE_L) + grp_f(k, s);
  endfunction

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [2:0]       drn_q, drn_d;
  logic [3:0]       stage_q, stage_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG_N-1:0] rd_a_q, rd_a_d;
  logic [LOG_N-1:0] rd_b_q, rd_b_d;
  logic [LOG_N-1:0] tw_q, tw_d;

  logic             pipe_en_q [D];
  logic [LOG_N-1:0] pipe_a_q  [D];
  logic [LOG_N-1:0] pipe_b_q  [D];

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    drn_d   = drn_q;
    stage_d = stage_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          k_d     = '0;
          stage_d = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          k_d     = '0;
          drn_d   = 3'd0;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_LAST) begin
          drn_d = 3'd0;
          if (stage_q == STG_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            stage_d = stage_q + 4'd1;
          end
        end else begin
          drn_d = drn_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
        drn_d   = 3'd0;
        stage_d = 4'd0;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    rd_en_d = (state_d == S_RUN);
    if (rd_en_d) begin
      rd_a_d = addr_a_f(k_d, stage_d);
      rd_b_d = addr_a_f(k_d, stage_d) + half_f(stage_d);
      tw_d   = tw_f(k_d, stage_d);
    end else begin
      rd_a_d = '0;
      rd_b_d = '0;
      tw_d   = '0;
    end
  end

  // State, counters and read-side output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      drn_q   <= 3'd0;
      stage_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drn_q   <= drn_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
    end
  end

  // Write-back replay: D-deep shift of the issued read strobe and pair addresses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        pipe_en_q[i] <= 1'b0;
        pipe_a_q[i]  <= '0;
        pipe_b_q[i]  <= '0;
      end
    end else begin
      pipe_en_q[0] <= rd_en_q;
      pipe_a_q[0]  <= rd_a_q;
      pipe_b_q[0]  <= rd_b_q;
      for (int i = 1; i < D; i++) begin
        pipe_en_q[i] <= pipe_en_q[i-1];
        pipe_a_q[i]  <= pipe_a_q[i-1];
        pipe_b_q[i]  <= pipe_b_q[i-1];
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_a_q;
  assign bus.rd_addr_b = rd_b_q;
  assign bus.tw_idx    = tw_q;
  assign bus.stage     = stage_q;
  assign bus.wr_en     = pipe_en_q[D-1];
  assign bus.wr_addr_a = pipe_a_q[D-1];
  assign bus.wr_addr_b = pipe_b_q[D-1];

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Scoreboard bench for ntt_stage_ctrl at LOG_N=8, BF_LAT=3: the driver queues expected reads,
// writes and done pulses per pass; a negedge monitor pops and compares whatever the DUT shows.
module tb_ntt_stage_ctrl;
  localparam int LOG_N = 8;
  localparam int N     = 256;
  localparam int D     = 4;
  localparam int SD    = 132;
  localparam int PASS  = 1057;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   pass_base = -1;

  typedef struct {int cyc; int a; int b; int tw; int st;} rd_t;
  typedef struct {int cyc; int a; int b;} wr_t;
  rd_t rd_q[$];
  wr_t wr_q[$];
  int  done_q[$];

  // Hand-computed reads: cycle relative to the start edge, addr_a, addr_b, tw_idx.
  int hv [7][4] = '{'{1, 0, 128, 0}, '{2, 1, 129, 0}, '{128, 127, 255, 0},
                    '{133, 0, 64, 1}, '{197, 128, 192, 2},
                    '{925, 0, 1, 127}, '{1052, 254, 255, 254}};

  ntt_stage_ctrl_if #(.LOG_N(LOG_N)) bus ();

  ntt_stage_ctrl #(.LOG_N(LOG_N), .BF_LAT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_pass(input int base);
    rd_t r;
    wr_t w;
    int  idx;
    int  half;
    for (int s = 0; s < LOG_N; s++) begin
      idx  = 0;
      half = N >> (s + 1);
      for (int g = 0; g < (1 << s); g++) begin
        for (int j = 0; j < half; j++) begin
          r.cyc = base + s * SD + idx + 1;
          r.a   = g * 2 * half + j;
          r.b   = r.a + half;
          r.tw  = (1 << s) - 1 + g;
          r.st  = s;
          rd_q.push_back(r);
          w.cyc = r.cyc + D;
          w.a   = r.a;
          w.b   = r.b;
          wr_q.push_back(w);
          idx++;
        end
      end
    end
    done_q.push_back(base + PASS);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  int'(bus.busy), 0);
    chk({tag, "_done"},  int'(bus.done), 0);
    chk({tag, "_rd_en"}, int'(bus.rd_en), 0);
    chk({tag, "_rd_a"},  int'(bus.rd_addr_a), 0);
    chk({tag, "_rd_b"},  int'(bus.rd_addr_b), 0);
    chk({tag, "_tw"},    int'(bus.tw_idx), 0);
    chk({tag, "_stage"}, int'(bus.stage), 0);
    chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
    chk({tag, "_wr_a"},  int'(bus.wr_addr_a), 0);
    chk({tag, "_wr_b"},  int'(bus.wr_addr_b), 0);
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_rd_left"},   rd_q.size(), 0);
    chk({tag, "_wr_left"},   wr_q.size(), 0);
    chk({tag, "_done_left"}, done_q.size(), 0);
    chk({tag, "_busy"},      int'(bus.busy), 0);
  endtask

  // Monitor: consume expectations whenever the DUT presents a read, write or done.
  always @(negedge clk) begin : monitor
    rd_t r;
    wr_t w;
    int  dc;
    if (bus.rd_en) begin
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        r = rd_q.pop_front();
        chk("rd_cycle", cyc, r.cyc);
        chk("rd_addr_a", int'(bus.rd_addr_a), r.a);
        chk("rd_addr_b", int'(bus.rd_addr_b), r.b);
        chk("tw_idx", int'(bus.tw_idx), r.tw);
        chk("stage", int'(bus.stage), r.st);
        chk("rd_busy", int'(bus.busy), 1);
      end
      if (pass_base >= 0) begin
        for (int i = 0; i < 7; i++) begin
          if (cyc - pass_base == hv[i][0]) begin
            chk("hand_rd_a", int'(bus.rd_addr_a), hv[i][1]);
            chk("hand_rd_b", int'(bus.rd_addr_b), hv[i][2]);
            chk("hand_tw", int'(bus.tw_idx), hv[i][3]);
          end
        end
      end
    end else begin
      chk("idle_rd_a", int'(bus.rd_addr_a), 0);
      chk("idle_rd_b", int'(bus.rd_addr_b), 0);
      chk("idle_tw", int'(bus.tw_idx), 0);
    end
    if (bus.wr_en) begin
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        w = wr_q.pop_front();
        chk("wr_cycle", cyc, w.cyc);
        chk("wr_addr_a", int'(bus.wr_addr_a), w.a);
        chk("wr_addr_b", int'(bus.wr_addr_b), w.b);
      end
      if (pass_base >= 0 && cyc - pass_base == 5) begin
        chk("hand_wr_a", int'(bus.wr_addr_a), 0);
        chk("hand_wr_b", int'(bus.wr_addr_b), 128);
      end
    end
    if (bus.done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        dc = done_q.pop_front();
        chk("done_cycle", cyc, dc);
      end
      chk("done_busy", int'(bus.busy), 1);
      if (pass_base >= 0) chk("hand_done_cycle", cyc - pass_base, PASS);
    end
  end

  initial begin : driver
    int base;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) tick();
    check_all_zero("idle_wait");

    // Pass 1: single start pulse, plus a stray start mid-pass that must be ignored.
    base = cyc;
    pass_base = base;
    push_pass(base);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("p1_busy_after_start", int'(bus.busy), 1);
    wait_until(base + 500);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_until(base + PASS + 1);
    chk("p1_done_low_after", int'(bus.done), 0);
    check_drained("p1");
    repeat (2) tick();

    // Pass 2: start held through the whole pass including the DONE cycle.
    base = cyc;
    pass_base = base;
    push_pass(base);
    bus.start = 1'b1;
    wait_until(base + PASS);
    chk("p2_done_now", int'(bus.done), 1);
    tick();
    bus.start = 1'b0;
    chk("p2_idle_after_done", int'(bus.busy), 0);
    repeat (4) tick();
    check_drained("p2");

    // Pass 3: reset during stage 3 RUN aborts everything, including pending writes.
    base = cyc;
    pass_base = base;
    push_pass(base);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_until(base + 3 * SD + 20);
    chk("p3_in_stage3", int'(bus.stage), 3);
    chk("p3_reading", int'(bus.rd_en), 1);
    rst_n = 1'b0;
    tick();
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    check_all_zero("midreset");
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      chk("post_reset_wr_en", int'(bus.wr_en), 0);
      chk("post_reset_busy", int'(bus.busy), 0);
    end

    // Pass 4: a fresh full pass after the abort.
    base = cyc;
    pass_base = base;
    push_pass(base);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_until(base + PASS + 1);
    check_drained("p4");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ntt_stage_ctrl.md
NTT_STAGE_CTRL -- requirements
Module: ntt_stage_ctrl

Interface
REQ-001 SHALL have parameter LOG_N, default 8, log2 of transform size N (legal 2..10).
REQ-002 SHALL have parameter BF_LAT, default 3, butterfly datapath latency in cycles (legal 0..7).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request one full NTT pass; sampled only in IDLE.
REQ-006 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-007 SHALL have port done  output  1  one-cycle pulse at pass completion.
REQ-008 SHALL have port rd_en  output  1  coefficient-memory read strobe, one butterfly pair per cycle.
REQ-009 SHALL have ports rd_addr_a and rd_addr_b  output  LOG_N each  read addresses of the butterfly pair.
REQ-010 SHALL have port tw_idx  output  LOG_N  twiddle-ROM index for the pair issued with rd_en.
REQ-011 SHALL have port stage  output  4  current stage index, 0..LOG_N-1.
REQ-012 SHALL have port wr_en  output  1  write-back strobe for the butterfly results.
REQ-013 SHALL have ports wr_addr_a and wr_addr_b  output  LOG_N each  write-back addresses.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-015 SHALL define D = 1 + BF_LAT: one memory-read cycle plus butterfly latency.
REQ-016 IDLE: start=1 at an edge -> RUN, stage=0, k=0; start=0 -> stay IDLE.
REQ-017 RUN: rd_en=1 every cycle; k increments 0..N/2-1; after k=N/2-1 -> DRAIN, k cleared.
REQ-018 Per stage s: half = 2^(LOG_N-1-s), group = k >> (LOG_N-1-s), j = k & (half-1).
REQ-019 Pair addresses: rd_addr_a = group*2*half + j, rd_addr_b = rd_addr_a + half.
REQ-020 Twiddle index: tw_idx = (2^s - 1) + group, in LOG_N bits; the maximum value is N-2.
REQ-021 rd_addr_a, rd_addr_b and tw_idx SHALL be valid in every cycle in which rd_en=1, and SHALL be 0 otherwise.
REQ-022 wr_en, wr_addr_a and wr_addr_b SHALL equal rd_en, rd_addr_a and rd_addr_b delayed by exactly D cycles, via a D-deep shift pipeline.
REQ-023 DRAIN: SHALL last exactly D cycles with rd_en=0, so the final write of a stage is issued before the next stage's first read.
REQ-024 End of DRAIN: if stage < LOG_N-1 -> stage+1, RUN; else -> DONE.
REQ-025 DONE: done=1 and busy=1 for one cycle; then IDLE.
REQ-026 Stage duration SHALL be N/2 + D cycles.
REQ-027 With start accepted at edge 0, done SHALL be high in cycle LOG_N*(N/2+D)+1.
REQ-028 start while busy SHALL be ignored, with no queuing and no restart.
REQ-029 start asserted in the DONE cycle SHALL be ignored; a new pass SHALL require start=1 while in IDLE.
REQ-030 No input stall exists; the issue rate SHALL be exactly one pair per cycle in RUN.
REQ-031 Counters SHALL never wrap beyond N/2-1 or LOG_N-1; an implementation reaching any other value is an error.

Reset
REQ-032 rst_n=0 at an edge SHALL force IDLE, stage=0, k=0 and clear the whole delay pipeline.
REQ-033 Reset values SHALL be busy=0, done=0, rd_en=0, wr_en=0, and 0 on all address, tw_idx and stage outputs.
REQ-034 Reset mid-pass SHALL abort immediately; no wr_en SHALL appear after reset for reads issued before reset.
REQ-035 After reset release the block SHALL wait in IDLE for start.

Verification
REQ-036 Defaults, start pulse -> stage 0: first rd pair (0,128) tw 0; second pair (1,129) tw 0; last pair (127,255).
REQ-037 Stage 1: k=0 -> (0,64) tw 1; k=64 -> (128,192) tw 2.
REQ-038 Stage 7: k=0 -> (0,1) tw 127; k=127 -> (254,255) tw 254.
REQ-039 Each write SHALL lag its read by 4 cycles with matching addresses; first stage-1 read at cycle 133; done high exactly at cycle 1057 and nowhere else.
REQ-040 start held high for the whole pass -> exactly one done pulse per accepted start, with no restart mid-pass.
REQ-041 rst_n=0 during stage 3 RUN -> next cycle all outputs 0, no wr_en for 10 cycles; a new start then gives a full 1057-cycle pass.
